// File: rtl/i2s_master_core_if.sv
// Parallel-side bundle of the I2S master: stereo tx/rx frames with
// valid/ready handshakes and sticky error flags.
interface i2s_master_core_if #(
  parameter int DW = 24
);
  logic [DW-1:0] tx_l;
  logic [DW-1:0] tx_r;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_l;
  logic [DW-1:0] rx_r;
  logic          rx_valid;
  logic          rx_ready;
  logic          underrun;
  logic          overrun;
  logic          clr_err;

  modport master (
    output tx_l, tx_r, tx_valid,
    output rx_ready, clr_err,
    input  tx_ready, rx_l, rx_r,
    input  rx_valid, underrun, overrun
  );

  modport slave (
    input  tx_l, tx_r, tx_valid,
    input  rx_ready, clr_err,
    output tx_ready, rx_l, rx_r,
    output rx_valid, underrun, overrun
  );
endinterface

// File: rtl/i2s_master_core.sv
// I2S master transceiver: derives sclk/lrclk from mclk, serialises
// stereo tx frames and deserialises rx frames (I2S or left-justified).
module i2s_master_core #(
  parameter int DW       = 24,
  parameter int SLOT     = 32,
  parameter int MCLK_DIV = 4,
  parameter int JUSTIFY  = 0
) (
  input  logic i_mclk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_sclk,
  output logic o_lrclk,
  output logic o_dataout,
  input  logic i_datain,
  i2s_master_core_if.slave bus
);
  localparam int DVW = $clog2(MCLK_DIV);
  localparam int BW  = $clog2(2 * SLOT);
  localparam int IW  = $clog2(DW);

  localparam logic [DVW-1:0] DIV_LAST = DVW'(MCLK_DIV - 1);
  localparam logic [DVW-1:0] DIV_HALF = DVW'(MCLK_DIV / 2);
  localparam logic [BW-1:0]  BIT_LAST = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0]  SLOT_B   = BW'(SLOT);
  localparam logic [BW-1:0]  DW_B     = BW'(DW);
  localparam logic [BW-1:0]  DW1_B    = BW'(DW - 1);
  localparam logic [BW-1:0]  K_FIRST  =
    (JUSTIFY != 0) ? '0 : BW'(1);

  logic [DVW-1:0] r_div;
  logic [BW-1:0]  r_bit;
  logic           r_run;
  logic           r_sclk;
  logic           r_lrclk;
  logic           r_dout;
  logic [DW-1:0]  r_hold_l;
  logic [DW-1:0]  r_hold_r;
  logic           r_hold_full;
  logic [DW-1:0]  r_txf_l;
  logic [DW-1:0]  r_txf_r;
  logic [DW-1:0]  r_rxs_l;
  logic [DW-1:0]  r_rxs_r;
  logic [DW-1:0]  r_rx_l;
  logic [DW-1:0]  r_rx_r;
  logic           r_rx_valid;
  logic           r_rx_done;
  logic           r_under;
  logic           r_over;

  logic           w_fall;
  logic           w_rise;
  logic           w_start;
  logic           w_xfer;
  logic           w_under_set;
  logic           w_over_set;
  logic [DVW-1:0] w_div_nx;
  logic [BW-1:0]  w_bit_nx;
  logic [BW-1:0]  w_k_nx;
  logic [BW-1:0]  w_kd_nx;
  logic [BW-1:0]  w_k_cur;
  logic [BW-1:0]  w_kd_cur;
  logic           w_ch_nx;
  logic           w_ch_cur;
  logic           w_dpos_nx;
  logic           w_dpos_cur;
  logic [IW-1:0]  w_idx;
  logic [DW-1:0]  w_src_l;
  logic [DW-1:0]  w_src_r;
  logic [DW-1:0]  w_txf_l;
  logic [DW-1:0]  w_txf_r;
  logic [DW-1:0]  w_word;
  logic           w_dout_nx;

  always_comb begin
    // First enabled cycle is forced to be a fall tick at bit 0.
    w_fall   = i_enable && (!r_run || r_div == DIV_LAST);
    w_rise   = i_enable && r_run &&
               (r_div == DIV_HALF - 1'b1);
    w_div_nx = w_fall ? '0 : r_div + 1'b1;
    w_bit_nx = r_bit;
    if (w_fall)
      w_bit_nx = (!r_run || r_bit == BIT_LAST) ?
                 '0 : r_bit + 1'b1;
    w_start  = w_fall && (w_bit_nx == '0);

    w_ch_nx    = w_bit_nx >= SLOT_B;
    w_k_nx     = w_ch_nx ? w_bit_nx - SLOT_B : w_bit_nx;
    w_kd_nx    = w_k_nx - K_FIRST;
    w_dpos_nx  = w_kd_nx < DW_B;
    w_ch_cur   = r_bit >= SLOT_B;
    w_k_cur    = w_ch_cur ? r_bit - SLOT_B : r_bit;
    w_kd_cur   = w_k_cur - K_FIRST;
    w_dpos_cur = w_kd_cur < DW_B;

    w_xfer  = bus.tx_valid && !r_hold_full;
    w_src_l = '0;
    w_src_r = '0;
    if (r_hold_full) begin
      w_src_l = r_hold_l;
      w_src_r = r_hold_r;
    end else if (w_xfer) begin
      w_src_l = bus.tx_l;
      w_src_r = bus.tx_r;
    end
    w_under_set = w_start && !r_hold_full && !w_xfer;

    w_txf_l   = w_start ? w_src_l : r_txf_l;
    w_txf_r   = w_start ? w_src_r : r_txf_r;
    w_word    = w_ch_nx ? w_txf_r : w_txf_l;
    w_idx     = IW'(DW1_B - w_kd_nx);
    w_dout_nx = w_dpos_nx && w_word[w_idx];

    w_over_set = r_rx_done && r_rx_valid && !bus.rx_ready;
  end

  always_ff @(posedge i_mclk or negedge i_rst) begin
    if (!i_rst) begin
      r_div       <= '0;
      r_bit       <= '0;
      r_run       <= 1'b0;
      r_sclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_dout      <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_hold_full <= 1'b0;
      r_txf_l     <= '0;
      r_txf_r     <= '0;
      r_rxs_l     <= '0;
      r_rxs_r     <= '0;
      r_rx_l      <= '0;
      r_rx_r      <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_done   <= 1'b0;
      r_under     <= 1'b0;
      r_over      <= 1'b0;
    end else begin
      r_run <= i_enable;
      if (!i_enable) begin
        r_div   <= '0;
        r_bit   <= '0;
        r_sclk  <= 1'b0;
        r_lrclk <= 1'b0;
        r_dout  <= 1'b0;
      end else begin
        r_div  <= w_div_nx;
        r_bit  <= w_bit_nx;
        r_sclk <= w_div_nx >= DIV_HALF;
        if (w_fall) begin
          r_lrclk <= w_ch_nx;
          r_dout  <= w_dout_nx;
        end
      end

      if (w_start) begin
        r_txf_l     <= w_src_l;
        r_txf_r     <= w_src_r;
        r_hold_full <= 1'b0;
      end else if (w_xfer) begin
        r_hold_l    <= bus.tx_l;
        r_hold_r    <= bus.tx_r;
        r_hold_full <= 1'b1;
      end

      if (w_rise && w_dpos_cur) begin
        if (w_ch_cur)
          r_rxs_r <= {r_rxs_r[DW-2:0], i_datain};
        else
          r_rxs_l <= {r_rxs_l[DW-2:0], i_datain};
      end
      r_rx_done <= w_rise && w_ch_cur &&
                   (w_kd_cur == DW1_B);

      if (r_rx_done) begin
        r_rx_l     <= r_rxs_l;
        r_rx_r     <= r_rxs_r;
        r_rx_valid <= 1'b1;
      end else if (bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_under_set)      r_under <= 1'b1;
      else if (bus.clr_err) r_under <= 1'b0;
      if (w_over_set)       r_over  <= 1'b1;
      else if (bus.clr_err) r_over  <= 1'b0;
    end
  end

  assign o_sclk       = r_sclk;
  assign o_lrclk      = r_lrclk;
  assign o_dataout    = r_dout;
  assign bus.tx_ready = !r_hold_full;
  assign bus.rx_l     = r_rx_l;
  assign bus.rx_r     = r_rx_r;
  assign bus.rx_valid = r_rx_valid;
  assign bus.underrun = r_under;
  assign bus.overrun  = r_over;
endmodule

// File: tb/tb_i2s_master_core.sv
// Directed bench for i2s_master_core: I2S 24/32 instance and a
// left-justified 16/16 instance, both looped back dataout->datain.
module tb_i2s_master_core;
  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } fr_t;

  logic mclk = 1'b0;
  logic rst;
  logic en_a;
  logic en_b;
  logic sclk_a, lrclk_a, dout_a;
  logic sclk_b, lrclk_b, dout_b;
  int   n_run  = 0;
  int   n_fail = 0;
  int   n      = 0;
  fr_t  qa[$];
  fr_t  qb[$];

  i2s_master_core_if #(.DW(24)) bus_a ();
  i2s_master_core_if #(.DW(16)) bus_b ();

  i2s_master_core #(
    .DW(24), .SLOT(32), .MCLK_DIV(4), .JUSTIFY(0)
  ) u_a (
    .i_mclk(mclk), .i_rst(rst), .i_enable(en_a),
    .o_sclk(sclk_a), .o_lrclk(lrclk_a),
    .o_dataout(dout_a), .i_datain(dout_a),
    .bus(bus_a)
  );

  i2s_master_core #(
    .DW(16), .SLOT(16), .MCLK_DIV(4), .JUSTIFY(1)
  ) u_b (
    .i_mclk(mclk), .i_rst(rst), .i_enable(en_b),
    .o_sclk(sclk_b), .o_lrclk(lrclk_b),
    .o_dataout(dout_b), .i_datain(dout_b),
    .bus(bus_b)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(negedge mclk);
    n++;
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (n=%0d)",
             tag, obs, exp, n);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (n=%0d)",
             tag, obs, exp, n);
    end
  endtask

  // Scoreboard pop: compares the frame just presented on rx.
  task automatic rx_pop(input string tag, input bit sel_b,
                        input logic [31:0] ol,
                        input logic [31:0] orr);
    fr_t e;
    int  sz;
    sz = sel_b ? qb.size() : qa.size();
    chk1({tag, "_qnonempty"}, sz > 0, 1'b1);
    if (sz > 0) begin
      e = sel_b ? qb.pop_front() : qa.pop_front();
      chkw({tag, "_l"}, ol, e.l);
      chkw({tag, "_r"}, orr, e.r);
    end
  endtask

  // I2S: 64 sclk frame, data at k=1..24 MSB first.
  function automatic logic exp_a(int nn, logic [23:0] l,
                                 logic [23:0] r);
    int b;
    int k;
    logic [23:0] w;
    b = (nn / 4) % 64;
    k = b % 32;
    w = (b >= 32) ? r : l;
    if (k >= 1 && k <= 24) return w[24-k];
    return 1'b0;
  endfunction

  // Left-justified: 32 sclk frame, data at k=0..15.
  function automatic logic exp_b(int nn, logic [15:0] l,
                                 logic [15:0] r);
    int b;
    int k;
    logic [15:0] w;
    b = (nn / 4) % 32;
    k = b % 16;
    w = (b >= 16) ? r : l;
    return w[15-k];
  endfunction

  initial begin
    rst            = 1'b0;
    en_a           = 1'b0;
    en_b           = 1'b0;
    bus_a.tx_l     = '0;
    bus_a.tx_r     = '0;
    bus_a.tx_valid = 1'b0;
    bus_a.rx_ready = 1'b1;
    bus_a.clr_err  = 1'b0;
    bus_b.tx_l     = '0;
    bus_b.tx_r     = '0;
    bus_b.tx_valid = 1'b0;
    bus_b.rx_ready = 1'b1;
    bus_b.clr_err  = 1'b0;
    repeat (3) step();

    // Reset state
    chk1("rst_sclk", sclk_a, 1'b0);
    chk1("rst_lrclk", lrclk_a, 1'b0);
    chk1("rst_dout", dout_a, 1'b0);
    chk1("rst_txrdy", bus_a.tx_ready, 1'b1);
    chk1("rst_rxv", bus_a.rx_valid, 1'b0);
    chk1("rst_ur", bus_a.underrun, 1'b0);
    chk1("rst_ov", bus_a.overrun, 1'b0);
    chkw("rst_rxl", 32'(bus_a.rx_l), 32'h0);
    rst = 1'b1;
    step();

    // Free run with no tx data: clocks, zero data, underrun
    en_a = 1'b1;
    n    = -1;
    for (int i = 0; i < 520; i++) begin
      step();
      chk1("t2_sclk", sclk_a, (n % 4) >= 2);
      chk1("t2_lrclk", lrclk_a, (n % 256) >= 128);
      chk1("t2_dout", dout_a, 1'b0);
      if (n == 0) chk1("t2_ur_first", bus_a.underrun, 1'b1);
      if (n == 301) begin
        bus_a.clr_err = 1'b0;
        chk1("t2_ur_clr", bus_a.underrun, 1'b0);
      end
      if (n == 300) bus_a.clr_err = 1'b1;
      if (n == 511) chk1("t2_ur_low", bus_a.underrun, 1'b0);
      if (n == 512) chk1("t2_ur_reset", bus_a.underrun, 1'b1);
    end

    // Hold-register start, serial pattern, loopback rx
    en_a = 1'b0;
    rst  = 1'b0;
    step();
    rst            = 1'b1;
    bus_a.tx_l     = 24'hA5F00F;
    bus_a.tx_r     = 24'h123456;
    bus_a.tx_valid = 1'b1;
    step();
    chk1("t3_txrdy_full", bus_a.tx_ready, 1'b0);
    qa.push_back('{l: 32'hA5F00F, r: 32'h123456});
    qa.push_back('{l: 32'hA5F00F, r: 32'h123456});
    en_a = 1'b1;
    n    = -1;
    for (int i = 0; i < 512; i++) begin
      step();
      chk1("t3_dout", dout_a,
           exp_a(n, 24'hA5F00F, 24'h123456));
      chk1("t3_rxv", bus_a.rx_valid, (n % 256) == 227);
      if ((n % 256) == 227)
        rx_pop("t3_rx", 1'b0, 32'(bus_a.rx_l),
               32'(bus_a.rx_r));
      if (n == 0) chk1("t3_txrdy_start", bus_a.tx_ready, 1'b1);
      if (n == 1) chk1("t3_txrdy_refill", bus_a.tx_ready, 1'b0);
    end
    chk1("t3_ur", bus_a.underrun, 1'b0);

    // Overrun, then mid-frame async reset
    en_a           = 1'b0;
    bus_a.tx_valid = 1'b0;
    rst            = 1'b0;
    step();
    rst            = 1'b1;
    bus_a.rx_ready = 1'b0;
    bus_a.tx_l     = 24'h000001;
    bus_a.tx_r     = 24'h0000F1;
    bus_a.tx_valid = 1'b1;
    step();
    bus_a.tx_l = 24'h000002;
    bus_a.tx_r = 24'h0000F2;
    qa.push_back('{l: 32'h1, r: 32'hF1});
    qa.push_back('{l: 32'h2, r: 32'hF2});
    en_a = 1'b1;
    n    = -1;
    for (int i = 0; i < 700; i++) begin
      step();
      if (n == 1) bus_a.tx_valid = 1'b0;
      if (n == 227) begin
        rx_pop("t4_f1", 1'b0, 32'(bus_a.rx_l),
               32'(bus_a.rx_r));
        chk1("t4_rxv1", bus_a.rx_valid, 1'b1);
        chk1("t4_ov0", bus_a.overrun, 1'b0);
      end
      if (n == 400) chk1("t4_rxv_held", bus_a.rx_valid, 1'b1);
      if (n == 483) begin
        rx_pop("t4_f2", 1'b0, 32'(bus_a.rx_l),
               32'(bus_a.rx_r));
        chk1("t4_rxv2", bus_a.rx_valid, 1'b1);
        chk1("t4_ov1", bus_a.overrun, 1'b1);
        bus_a.rx_ready = 1'b1;
      end
      if (n == 484) begin
        chk1("t4_rxv_clr", bus_a.rx_valid, 1'b0);
        chk1("t4_ov_sticky", bus_a.overrun, 1'b1);
        bus_a.rx_ready = 1'b0;
        bus_a.clr_err  = 1'b1;
      end
      if (n == 485) begin
        chk1("t4_ov_clr", bus_a.overrun, 1'b0);
        bus_a.clr_err = 1'b0;
      end
      if (n == 674) break;
    end
    chk1("t5_pre_lrclk", lrclk_a, 1'b1);
    chk1("t5_pre_sclk", sclk_a, 1'b1);
    chk1("t5_pre_ur", bus_a.underrun, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t5_sclk", sclk_a, 1'b0);
    chk1("t5_lrclk", lrclk_a, 1'b0);
    chk1("t5_dout", dout_a, 1'b0);
    chk1("t5_txrdy", bus_a.tx_ready, 1'b1);
    chk1("t5_rxv", bus_a.rx_valid, 1'b0);
    chk1("t5_ur", bus_a.underrun, 1'b0);
    chk1("t5_ov", bus_a.overrun, 1'b0);
    chkw("t5_rxl", 32'(bus_a.rx_l), 32'h0);
    chkw("t5_rxr", 32'(bus_a.rx_r), 32'h0);
    step();
    step();
    rst            = 1'b1;
    bus_a.rx_ready = 1'b1;
    qa.push_back('{l: 32'h0, r: 32'h0});
    n = -1;
    for (int i = 0; i < 256; i++) begin
      step();
      chk1("t5_run_lrclk", lrclk_a, n >= 128);
      chk1("t5_run_sclk", sclk_a, (n % 4) >= 2);
      chk1("t5_run_rxv", bus_a.rx_valid, n == 227);
      if (n == 0) chk1("t5_run_ur", bus_a.underrun, 1'b1);
      if (n == 227)
        rx_pop("t5_rx", 1'b0, 32'(bus_a.rx_l),
               32'(bus_a.rx_r));
    end
    en_a = 1'b0;

    // Left-justified instance, bypass then hold start
    bus_b.tx_l     = 16'h8001;
    bus_b.tx_r     = 16'h4002;
    bus_b.tx_valid = 1'b1;
    qb.push_back('{l: 32'h8001, r: 32'h4002});
    qb.push_back('{l: 32'h8001, r: 32'h4002});
    en_b = 1'b1;
    n    = -1;
    for (int i = 0; i < 256; i++) begin
      step();
      chk1("b_dout", dout_b, exp_b(n, 16'h8001, 16'h4002));
      chk1("b_lrclk", lrclk_b, (n % 128) >= 64);
      chk1("b_sclk", sclk_b, (n % 4) >= 2);
      chk1("b_rxv", bus_b.rx_valid, (n % 128) == 127);
      if ((n % 128) == 127)
        rx_pop("b_rx", 1'b1, 32'(bus_b.rx_l),
               32'(bus_b.rx_r));
    end
    chk1("b_ur", bus_b.underrun, 1'b0);
    en_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_master_core.md
Name: i2s_master_core

Overview:
- Parametrised I2S master transceiver; next generation of the team's 24-bit Pmod I2S2 driver.
- Generates sclk and lrclk from mclk itself rather than edge-detecting external clocks.
- Supports configurable sample width, slot width, mclk:sclk ratio, and I2S or left-justified framing.
- Moves stereo frames over valid/ready handshakes, with sticky underrun/overrun flags. Sits between the audio DSP pipeline and the Pmod pins.

Parameters:
- DW, 24: sample width in bits, 8..32.
- SLOT, 32: sclk periods per channel slot. Must be >= DW+1 when JUSTIFY=0, and >= DW when JUSTIFY=1.
- MCLK_DIV, 4: mclk cycles per sclk period. Even, >= 2.
- JUSTIFY, 0: 0 = I2S (MSB one sclk after the lrclk edge); 1 = left-justified (MSB on the lrclk edge).

Ports:
- mclk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run/stop for serial clocks and framing.
- sclk  out  1  serial bit clock.
- lrclk  out  1  word select; 0 = left, 1 = right.
- dataout  out  1  serial transmit data.
- datain  in  1  serial receive data.
- tx_l, tx_r  in  DW each  left/right transmit samples.
- tx_valid  in  1  transmit frame offered.
- tx_ready  out  1  holding register empty.
- rx_l, rx_r  out  DW each  last received frame.
- rx_valid  out  1  received frame available.
- rx_ready  in  1  consumer accepts the received frame.
- underrun  out  1  sticky: a frame started with no tx data.
- overrun  out  1  sticky: an unconsumed rx frame was overwritten.
- clr_err  in  1  clears both sticky flags.

Behaviour:
- Reset (rst low, async) sets: sclk=0, lrclk=0, dataout=0, tx_ready=1, rx_l=rx_r=0, rx_valid=0, underrun=0, overrun=0. Counters, holding register, shift registers and partial rx data are cleared. Reset takes effect immediately, mid-frame included.
- All outputs are registered.
- Divider div_cnt counts 0..MCLK_DIV-1.
  - sclk=0 for div_cnt < MCLK_DIV/2, 1 otherwise.
  - Fall tick: div_cnt wraps to 0. Rise tick: div_cnt reaches MCLK_DIV/2.
- Bit counter bit_cnt counts 0..2*SLOT-1 and advances on fall ticks.
  - lrclk = (bit_cnt >= SLOT). lrclk changes only on fall ticks.
  - k = bit_cnt mod SLOT.
  - Data bit positions: k = 1..DW when JUSTIFY=0; k = 0..DW-1 when JUSTIFY=1. All other k are padding.
- Enable control:
  - enable low: div_cnt, bit_cnt, sclk, lrclk and dataout are held at 0. A partial frame is discarded, and rx state plus the holding register are retained.
  - The first mclk cycle with enable high is a fall tick with bit_cnt=0, i.e. a frame start.
- TX path:
  - Holding register; tx_ready = !hold_full. A transfer occurs when tx_valid && tx_ready.
  - Frame start (fall tick with new bit_cnt=0), in priority order:
    - hold_full: load both shift registers from hold and clear hold_full.
    - Else, transfer in the same cycle: bypass tx_l/tx_r directly into the shifters; hold stays empty; no underrun.
    - Else: shift in zeros and set underrun.
  - On each fall tick, dataout = the bit for the new bit_cnt: MSB-first at data positions, 0 at padding.
- RX path:
  - datain is sampled on rise ticks at data positions, MSB-first, into a left or right shifter selected by lrclk.
  - The cycle after the rise tick sampling the right channel's last data bit: rx_l/rx_r are updated from the shifters and rx_valid is set.
  - rx_valid clears on rx_valid && rx_ready.
  - A new frame completing while rx_valid=1 and rx_ready=0 overwrites rx_l/rx_r, keeps rx_valid=1 and sets overrun.
  - If rx_ready is high in that same cycle, there is no overrun.
- Flags: clr_err clears underrun and overrun. If a set and a clear coincide, the set wins.
- Default timing: frame = 64 sclk = 256 mclk; lrclk low for mclk 0..127 of each frame.

Test Plan:
- Reset, enable=1, tx_valid=0 → sclk period 4 mclk, 50% duty; lrclk period 256 mclk; dataout=0 throughout; underrun=1 from the first frame-start cycle; clr_err pulse → underrun=0, then re-set at the next frame start.
- tx_l=24'hA5F00F, tx_r=24'h123456, tx_valid=1 before enable → tx_ready drops after the handshake and the frame starts via hold. Left slot: dataout=0 at k=0, then bits 1010_0101_1111_0000_0000_1111 at k=1..24, then 0 at k=25..31. Right slot carries 24'h123456 identically. No underrun.
- Loopback dataout→datain with rx_ready=1 → rx_valid pulses once per frame, 1 mclk wide, with rx_l=24'hA5F00F and rx_r=24'h123456. The pulse asserts the cycle after the rise tick at bit_cnt=56.
- JUSTIFY=1, DW=16, SLOT=16, tx_l=16'h8001 → dataout=1 at k=0 coincident with lrclk falling, 1 at k=15, 0 between; frame = 32 sclk.
- Loopback with rx_ready=0 for two frames, sending 24'h000001 then 24'h000002 → overrun=1, rx_l=24'h000002, rx_valid stays 1. rx_ready=1 for one cycle → rx_valid=0.
- rst pulled low at bit_cnt=40 → all outputs take reset values asynchronously. Release with enable=1 → a fresh frame starts with lrclk=0 and bit_cnt=0, and no stale rx_valid appears.
